// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension, writeback select,
// cache-stall bubble insertion, stall-cycle counter and stall watchdog.
module mem_wb_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int EXTEND_LOADS = 1,
    parameter int STALL_LIMIT  = 64,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [DATA_WIDTH-1:0] ReadDataM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [4:0]            RdM,
    input  logic [2:0]            funct3M,
    input  logic                  cache_busy,
    output logic                  RegWriteW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic                  misaligned_load,
    output logic                  stall_timeout,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    localparam int RUN_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic {RUN, WAIT} state_t;

    state_t                  state_q, state_d;
    logic                    capture;
    logic [RUN_W-1:0]        busy_run, busy_run_next;
    logic [DATA_WIDTH-1:0]   load_data, result_sel;
    logic [1:0]              off;
    logic                    misaligned;

    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [2:0]            f3,
        input logic [1:0]            a
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = raw[{a, 3'b000} +: 8];
        h = raw[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return DATA_WIDTH'(b);
            3'b100:  return DATA_WIDTH'($unsigned(b));
            3'b001:  return DATA_WIDTH'(h);
            3'b101:  return DATA_WIDTH'($unsigned(h));
            default: return raw;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (v >= RUN_W'(STALL_LIMIT)) ? RUN_W'(STALL_LIMIT) : v + RUN_W'(1);
    endfunction

    assign off           = ALUResultM[1:0];
    assign busy_run_next = cache_busy ? sat_inc_run(busy_run) : '0;

    // Alignment only matters when the memory returns a raw word.
    always_comb begin
        load_data  = ReadDataM;
        misaligned = 1'b0;
        if (EXTEND_LOADS != 0) begin
            load_data  = extend_load(ReadDataM, funct3M, off);
            misaligned = (ResultSrcM == 2'b01) && RegWriteM &&
                         (((funct3M[1:0] == 2'b01) && off[0]) ||
                          ((funct3M == 3'b010) && (off != 2'b00)));
        end
    end

    always_comb begin
        case (ResultSrcM)
            2'b00:   result_sel = ALUResultM;
            2'b01:   result_sel = load_data;
            2'b10:   result_sel = PCPlus4M;
            default: result_sel = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            RUN:     if (cache_busy) state_d = WAIT;
                     else            capture = 1'b1;
            WAIT:    if (!cache_busy) begin
                         state_d = RUN;
                         capture = 1'b1;
                     end
            default: state_d = RUN;
        endcase
    end

    // MEM -> WB register boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            busy_run        <= '0;
            stall_timeout   <= 1'b0;
            stall_cycles    <= '0;
            RegWriteW       <= 1'b0;
            RdW             <= '0;
            ResultW         <= '0;
            misaligned_load <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_run <= busy_run_next;
            if (cache_busy)
                stall_cycles <= sat_inc_cnt(stall_cycles);
            if (busy_run_next == RUN_W'(STALL_LIMIT))
                stall_timeout <= 1'b1;
            if (capture) begin
                RegWriteW       <= RegWriteM && (RdM != 5'd0) && !misaligned;
                RdW             <= RdM;
                ResultW         <= result_sel;
                misaligned_load <= misaligned;
            end else begin
                RegWriteW       <= 1'b0;
                RdW             <= '0;
                ResultW         <= '0;
                misaligned_load <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a short watchdog limit.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [31:0] ReadDataM = '0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] PCPlus4M = '0;
    logic [4:0]  RdM = '0;
    logic [2:0]  funct3M = '0;
    logic        cache_busy = 1'b0;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        misaligned_load;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(
        .DATA_WIDTH(32), .EXTEND_LOADS(1), .STALL_LIMIT(4), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ReadDataM(ReadDataM), .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .funct3M(funct3M), .cache_busy(cache_busy),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .misaligned_load(misaligned_load), .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [1:0] src, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [4:0] rd);
        RegWriteM = rw; ResultSrcM = src; funct3M = f3; ALUResultM = addr;
        ReadDataM = rdata; PCPlus4M = pc4; RdM = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if ({RegWriteW, RdW, ResultW, misaligned_load, stall_timeout, stall_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rw=%b rd=%0d res=%h ml=%b to=%b sc=%0d required all 0",
                     RegWriteW, RdW, ResultW, misaligned_load, stall_timeout, stall_cycles);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_byte_loads();
        drive(1'b1, 2'b01, 3'b000, 32'h103, 32'h80FF_1234, 32'h0, 5'd5);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || RdW !== 5'd5 || ResultW !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb got rw=%b rd=%0d res=%h required 1 5 ffffff80", RegWriteW, RdW, ResultW);
        end
        drive(1'b1, 2'b01, 3'b100, 32'h103, 32'h80FF_1234, 32'h0, 5'd5);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || ResultW !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu got rw=%b res=%h required 1 00000080", RegWriteW, ResultW);
        end
        drive(1'b1, 2'b01, 3'b000, 32'h101, 32'h80FF_1234, 32'h0, 5'd6);
        step();
        checks++;
        if (ResultW !== 32'h0000_0012) begin
            errors++;
            $display("FAIL lb_off1 got res=%h required 00000012", ResultW);
        end
    endtask

    task automatic test_half_word_loads();
        drive(1'b1, 2'b01, 3'b001, 32'h102, 32'h8001_7FFF, 32'h0, 5'd9);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || RdW !== 5'd9 || ResultW !== 32'hFFFF_8001 || misaligned_load !== 1'b0) begin
            errors++;
            $display("FAIL lh got rw=%b rd=%0d res=%h ml=%b required 1 9 ffff8001 0",
                     RegWriteW, RdW, ResultW, misaligned_load);
        end
        drive(1'b1, 2'b01, 3'b101, 32'h101, 32'h8001_7FFF, 32'h0, 5'd9);
        step();
        checks++;
        if (RegWriteW !== 1'b0 || misaligned_load !== 1'b1 || ResultW !== 32'h0000_7FFF) begin
            errors++;
            $display("FAIL lhu_misaligned got rw=%b ml=%b res=%h required 0 1 00007fff",
                     RegWriteW, misaligned_load, ResultW);
        end
        drive(1'b1, 2'b01, 3'b010, 32'h104, 32'h1234_5678, 32'h0, 5'd10);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || misaligned_load !== 1'b0 || ResultW !== 32'h1234_5678) begin
            errors++;
            $display("FAIL lw got rw=%b ml=%b res=%h required 1 0 12345678", RegWriteW, misaligned_load, ResultW);
        end
        drive(1'b1, 2'b01, 3'b010, 32'h106, 32'h1234_5678, 32'h0, 5'd10);
        step();
        checks++;
        if (RegWriteW !== 1'b0 || misaligned_load !== 1'b1) begin
            errors++;
            $display("FAIL lw_misaligned got rw=%b ml=%b required 0 1", RegWriteW, misaligned_load);
        end
        drive(1'b0, 2'b01, 3'b001, 32'h103, 32'h8001_7FFF, 32'h0, 5'd11);
        step();
        checks++;
        if (RegWriteW !== 1'b0 || misaligned_load !== 1'b0) begin
            errors++;
            $display("FAIL no_write_no_misalign got rw=%b ml=%b required 0 0", RegWriteW, misaligned_load);
        end
    endtask

    task automatic test_result_select();
        drive(1'b1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0040, 5'd1);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || RdW !== 5'd1 || ResultW !== 32'h40) begin
            errors++;
            $display("FAIL pc4 got rw=%b rd=%0d res=%h required 1 1 00000040", RegWriteW, RdW, ResultW);
        end
        drive(1'b1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0040, 5'd0);
        step();
        checks++;
        if (RegWriteW !== 1'b0 || ResultW !== 32'h40) begin
            errors++;
            $display("FAIL pc4_x0 got rw=%b res=%h required 0 00000040", RegWriteW, ResultW);
        end
        drive(1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h1111_1111, 32'h4, 5'd3);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || ResultW !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL alu got rw=%b res=%h required 1 deadbeef", RegWriteW, ResultW);
        end
        drive(1'b1, 2'b11, 3'b000, 32'hDEAD_BEEF, 32'h1111_1111, 32'h4, 5'd3);
        step();
        checks++;
        if (ResultW !== 32'h0) begin
            errors++;
            $display("FAIL reserved_src got res=%h required 00000000", ResultW);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 2'b01, 3'b000, 32'h103, 32'h80FF_1234, 32'h0, 5'd5);
        cache_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (RegWriteW !== 1'b0 || RdW !== 5'd0 || ResultW !== 32'h0) begin
                errors++;
                $display("FAIL stall_bubble[%0d] got rw=%b rd=%0d res=%h required 0 0 0", i, RegWriteW, RdW, ResultW);
            end
        end
        checks++;
        if (stall_cycles !== 32'd3 || stall_timeout !== 1'b0) begin
            errors++;
            $display("FAIL stall_count got sc=%0d to=%b required 3 0", stall_cycles, stall_timeout);
        end
        cache_busy = 1'b0;
        step();
        checks++;
        if (RegWriteW !== 1'b1 || RdW !== 5'd5 || ResultW !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL stall_release got rw=%b rd=%0d res=%h required 1 5 ffffff80", RegWriteW, RdW, ResultW);
        end
    endtask

    task automatic test_timeout();
        cache_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (stall_timeout !== (i >= 4)) begin
                errors++;
                $display("FAIL timeout_edge%0d got %b required %b", i, stall_timeout, (i >= 4));
            end
        end
        cache_busy = 1'b0;
        step();
        checks++;
        if (stall_timeout !== 1'b1 || stall_cycles !== 32'd9) begin
            errors++;
            $display("FAIL timeout_sticky got to=%b sc=%0d required 1 9", stall_timeout, stall_cycles);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall_timeout !== 1'b0 || stall_cycles !== 32'd0 || RegWriteW !== 1'b0 || ResultW !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rst got to=%b sc=%0d rw=%b res=%h required 0 0 0 0",
                     stall_timeout, stall_cycles, RegWriteW, ResultW);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        drive(1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 5'd7);
        cache_busy = 1'b1;
        repeat (5) step();
        checks++;
        if (stall_cycles !== 32'd5 || RegWriteW !== 1'b0) begin
            errors++;
            $display("FAIL wait_count got sc=%0d rw=%b required 5 0", stall_cycles, RegWriteW);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({RegWriteW, RdW, ResultW, misaligned_load, stall_timeout, stall_cycles} !== '0) begin
            errors++;
            $display("FAIL async_rst got rw=%b rd=%0d res=%h ml=%b to=%b sc=%0d required all 0",
                     RegWriteW, RdW, ResultW, misaligned_load, stall_timeout, stall_cycles);
        end
        rst = 1'b0;
        cache_busy = 1'b0;
        step();
        checks++;
        if (RegWriteW !== 1'b1 || RdW !== 5'd7 || ResultW !== 32'h55 || stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL post_rst_capture got rw=%b rd=%0d res=%h sc=%0d required 1 7 00000055 0",
                     RegWriteW, RdW, ResultW, stall_cycles);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b01, 3'b101, 32'h202, 32'hABCD_0123, 32'h0, 5'd12);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || RdW !== 5'd12 || ResultW !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL b2b_first got rw=%b rd=%0d res=%h required 1 12 0000abcd", RegWriteW, RdW, ResultW);
        end
        drive(1'b1, 2'b01, 3'b000, 32'h201, 32'hABCD_0123, 32'h0, 5'd13);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || RdW !== 5'd13 || ResultW !== 32'h0000_0001) begin
            errors++;
            $display("FAIL b2b_second got rw=%b rd=%0d res=%h required 1 13 00000001", RegWriteW, RdW, ResultW);
        end
    endtask

    initial begin
        test_reset();
        test_byte_loads();
        test_half_word_loads();
        test_result_select();
        test_stall();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic, directly downstream of the memory stage. Consumes the memory stage's pass-through control, address and PC+4 signals, its read data and its cache stall flag.
- Aligns and extends load data, then selects the writeback result.
- Drives the register-file write port and the forwarding sources for the hazard unit.
- Inserts writeback bubbles while the cache stalls, and keeps a stall-cycle counter and a stall watchdog.

Parameters:
DATA_WIDTH, 32, datapath width
EXTEND_LOADS, 1, 1: align/extend raw word from memory; 0: ReadDataM used unmodified
STALL_LIMIT, 64, consecutive busy cycles before stall_timeout sets
CNT_WIDTH, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
RegWriteM  in  1  register write enable from memory stage
ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
ReadDataM  in  DATA_WIDTH  word-aligned raw read data
ALUResultM  in  DATA_WIDTH  ALU result / load address
PCPlus4M  in  DATA_WIDTH  link value
RdM  in  5  destination register
funct3M  in  3  load size/sign
cache_busy  in  1  memory stage stall
RegWriteW  out  1  register-file write enable
RdW  out  5  register-file write address
ResultW  out  DATA_WIDTH  register-file write data / forwarding value
misaligned_load  out  1  one-cycle pulse: dropped misaligned load
stall_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_WIDTH  saturating count of busy cycles

Behaviour:
- Reset, asynchronous, wins over everything: all outputs 0, FSM=RUN, internal busy-run counter 0.
- Latency: one cycle. Inputs sampled on the edge where cache_busy=0 appear on the W outputs in the following cycle.
- FSM states:
  - RUN: cache_busy=0 → capture inputs. cache_busy=1 → go to WAIT and load a bubble this edge.
  - WAIT: each edge with cache_busy=1 loads a bubble. First edge with cache_busy=0 captures inputs and returns to RUN.
- Bubble: RegWriteW<=0, RdW<=0, ResultW<=0, misaligned_load<=0.
- Capture: RegWriteW <= RegWriteM && (RdM!=0) && !misaligned. RdW<=RdM.
- ResultW by ResultSrcM:
  - 00 → ALUResultM
  - 01 → load data
  - 10 → PCPlus4M
  - 11 → 0
- Load data (EXTEND_LOADS=1), off=ALUResultM[1:0]:
  - funct3 000 LB: sign-extend byte[off]
  - 100 LBU: zero-extend byte[off]
  - 001 LH: sign-extend half[off[1]]
  - 101 LHU: zero-extend half[off[1]]
  - 010 LW: word
  - Any other funct3 with ResultSrcM=01: word passed through.
- Misaligned load (ResultSrcM=01 and RegWriteM=1):
  - LH/LHU with off[0]=1, or LW with off!=0.
  - Response: write suppressed, misaligned_load=1 for one cycle, ResultW still shows the extended value.
- EXTEND_LOADS=0: load data=ReadDataM; misaligned detection disabled.
- stall_cycles: +1 on every edge with cache_busy=1 outside reset. Saturates at all-ones.
- Watchdog:
  - Busy-run counter increments while cache_busy=1 and clears on cache_busy=0.
  - When it reaches STALL_LIMIT, stall_timeout sets. It clears only on rst.
  - Counter saturates at STALL_LIMIT.
- Simultaneous cases:
  - cache_busy falling in the same cycle as a new load: captured normally, no extra bubble.
  - Reset mid-WAIT: returns to RUN, the pending instruction is discarded, and upstream re-presents it.

Test Plan:
- LB at address 0x103, ReadDataM=0x80FF_1234, RdM=5 → next cycle RegWriteW=1, RdW=5, ResultW=0xFFFF_FF80. Same stimulus with LBU → 0x0000_0080.
- LH at address 0x102, ReadDataM=0x8001_7FFF → ResultW=0xFFFF_8001. LHU at address 0x101 → RegWriteW=0, misaligned_load pulses one cycle.
- ResultSrcM=10, PCPlus4M=0x0000_0040, RdM=1 → ResultW=0x40. Same stimulus with RdM=0 → RegWriteW=0.
- cache_busy high for 3 cycles with a load pending → RegWriteW=0 for 3 cycles, stall_cycles=3. On the edge where busy falls, the load is captured and RegWriteW=1 the next cycle.
- STALL_LIMIT=4, cache_busy held for 6 cycles → stall_timeout=1 after the 4th busy edge and stays set after busy falls. rst clears it.
- Assert rst while in WAIT with stall_cycles=5 → all outputs 0 immediately (asynchronous). After release, a capture occurs on the first edge with cache_busy=0.
